// File: rtl/nf_settings.sv
// rtl/nf_settings.sv - shared FSM state encoding and register offsets for nf_pwm_cap
package nf_settings;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_MEAS_HIGH = 2'd2,
    ST_MEAS_LOW  = 2'd3
  } cap_state_t;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_HIGH   = 2'd2;
  localparam logic [1:0] REG_PERIOD = 2'd3;

endpackage

// File: rtl/nf_sync.sv
// rtl/nf_sync.sv - multi-stage synchronizer for asynchronous inputs
module nf_sync #(
  parameter int W = 1,
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [N-1:0][W-1:0] stg;

  // shift the raw input through N flops so the last stage is settled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stg <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < N; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  assign q = stg[N-1];

endmodule

// File: rtl/nf_pwm_cap.sv
// rtl/nf_pwm_cap.sv - PWM high-time and period capture with register interface
module nf_pwm_cap
  import nf_settings::*;
#(
  parameter int CW     = 16,
  parameter int SYNC_N = 2
) (
  input  logic        pwm_clk,
  input  logic        pwm_resetn,
  input  logic        pwm_in,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  cap_state_t    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [CW-1:0] high_tmp, high_tmp_nx;
  logic [CW-1:0] high_r, period_r;
  logic          en_r, irq_en_r, valid_r, ovf_r;
  logic          pwm_s, pwm_d, rise, fall;
  logic          cap, ovf_set;
  logic          wr_ctrl, wr_status;
  logic          unused_bits;

  nf_sync #(.W(1), .N(SYNC_N)) u_sync (
    .clk    (pwm_clk),
    .resetn (pwm_resetn),
    .d      (pwm_in),
    .q      (pwm_s)
  );

  // one extra flop behind the synchronizer gives the previous level for edge detection
  always_ff @(posedge pwm_clk or negedge pwm_resetn) begin
    if (!pwm_resetn) pwm_d <= 1'b0;
    else             pwm_d <= pwm_s;
  end

  assign rise = pwm_s & ~pwm_d;
  assign fall = ~pwm_s & pwm_d;

  assign wr_ctrl   = we && (addr[3:2] == REG_CTRL);
  assign wr_status = we && (addr[3:2] == REG_STATUS);

  // only addr[3:2] and the defined wd fields carry meaning
  assign unused_bits = ^{addr[31:4], addr[1:0], wd[31:2]};

  // next-state and counter logic; overflow takes priority over edges
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    high_tmp_nx = high_tmp;
    cap         = 1'b0;
    ovf_set     = 1'b0;
    if (!en_r) begin
      state_nx = ST_IDLE;
      cnt_nx   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nx = ST_WAIT_RISE;
        end
        ST_WAIT_RISE: begin
          if (rise) begin
            state_nx = ST_MEAS_HIGH;
            cnt_nx   = CW'(1);
          end
        end
        ST_MEAS_HIGH: begin
          if (cnt == CNT_MAX) begin
            ovf_set  = 1'b1;
            state_nx = ST_WAIT_RISE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
            if (fall) begin
              high_tmp_nx = cnt;
              state_nx    = ST_MEAS_LOW;
            end
          end
        end
        ST_MEAS_LOW: begin
          if (cnt == CNT_MAX) begin
            ovf_set  = 1'b1;
            state_nx = ST_WAIT_RISE;
            cnt_nx   = '0;
          end else if (rise) begin
            cap      = 1'b1;
            state_nx = ST_MEAS_HIGH;
            cnt_nx   = CW'(1);
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        default: begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // FSM state register and measurement counters
  always_ff @(posedge pwm_clk or negedge pwm_resetn) begin
    if (!pwm_resetn) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      high_tmp <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      high_tmp <= high_tmp_nx;
    end
  end

  // control, status, result registers and interrupt; hardware set beats write-1-to-clear
  always_ff @(posedge pwm_clk or negedge pwm_resetn) begin
    if (!pwm_resetn) begin
      en_r     <= 1'b0;
      irq_en_r <= 1'b0;
      valid_r  <= 1'b0;
      ovf_r    <= 1'b0;
      high_r   <= '0;
      period_r <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en_r     <= wd[0];
        irq_en_r <= wd[1];
      end
      valid_r <= cap     | (valid_r & ~(wr_status & wd[0]));
      ovf_r   <= ovf_set | (ovf_r   & ~(wr_status & wd[1]));
      if (cap) begin
        high_r   <= high_tmp;
        period_r <= cnt;
      end
      irq <= irq_en_r & (valid_r | ovf_r);
    end
  end

  // combinational read mux, unused upper bits read as zero
  always_comb begin
    rd = '0;
    case (addr[3:2])
      REG_CTRL:   rd[1:0]    = {irq_en_r, en_r};
      REG_STATUS: rd[1:0]    = {ovf_r, valid_r};
      REG_HIGH:   rd[CW-1:0] = high_r;
      REG_PERIOD: rd[CW-1:0] = period_r;
      default:    rd         = '0;
    endcase
  end

endmodule

// File: tb/tb_nf_pwm_cap.sv
// tb/tb_nf_pwm_cap.sv - self-checking bench for nf_pwm_cap
module tb_nf_pwm_cap;
  import nf_settings::*;

  localparam int CW     = 8;
  localparam int SYNC_N = 2;

  logic        pwm_clk;
  logic        pwm_resetn;
  logic        pwm_in;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_high = 0;
  int exp_period = 0;

  nf_pwm_cap #(.CW(CW), .SYNC_N(SYNC_N)) dut (
    .pwm_clk    (pwm_clk),
    .pwm_resetn (pwm_resetn),
    .pwm_in     (pwm_in),
    .addr       (addr),
    .we         (we),
    .wd         (wd),
    .rd         (rd),
    .irq        (irq)
  );

  initial pwm_clk = 1'b0;
  always #5 pwm_clk = ~pwm_clk;

  task automatic tick();
    @(negedge pwm_clk);
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    addr = {28'd0, a, 2'b00};
    wd   = d;
    we   = 1'b1;
    @(negedge pwm_clk);
    we   = 1'b0;
    wd   = '0;
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
    addr = {28'd0, a, 2'b00};
    #1;
    d = rd;
  endtask

  task automatic pulse(input int h, input int l);
    pwm_in = 1'b1;
    repeat (h) tick();
    pwm_in = 1'b0;
    repeat (l) tick();
  endtask

  task automatic restart(input logic [31:0] ctrl);
    reg_wr(REG_CTRL, 32'd0);
    pwm_in = 1'b0;
    repeat (SYNC_N + 3) tick();
    reg_wr(REG_STATUS, 32'd3);
    reg_wr(REG_CTRL, ctrl);
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    pwm_resetn = 1'b0;
    pwm_in = 1'b0;
    we = 1'b0;
    wd = '0;
    addr = '0;
    repeat (3) tick();
    pwm_resetn = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) begin
      reg_rd(a[1:0], v);
      n_checks++;
      if (v !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_rd[%0d]: got 0x%08h expected 0x00000000", a, v);
      end
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq: got %b expected 0", irq);
    end
    n_checks++;
    if (dut.state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected %0d", dut.state, ST_IDLE);
    end
  endtask

  task automatic test_capture();
    logic [31:0] v;
    restart(32'd1);
    repeat (3) pulse(3, 5);
    pwm_in = 1'b1;
    repeat (SYNC_N + 4) tick();
    exp_high = 3;
    exp_period = 8;
    reg_rd(REG_HIGH, v);
    n_checks++;
    if (v !== exp_high) begin
      n_fail++;
      $display("FAIL cap_high: got %0d expected %0d", v, exp_high);
    end
    reg_rd(REG_PERIOD, v);
    n_checks++;
    if (v !== exp_period) begin
      n_fail++;
      $display("FAIL cap_period: got %0d expected %0d", v, exp_period);
    end
    reg_rd(REG_STATUS, v);
    n_checks++;
    if (v !== 32'd1) begin
      n_fail++;
      $display("FAIL cap_status: got 0x%0h expected 0x1", v);
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    int h, l;
    for (int t = 0; t < 5; t++) begin
      h = $urandom_range(12, 1);
      l = $urandom_range(12, 1);
      restart(32'd1);
      pulse(h, l);
      pulse(h, l);
      pwm_in = 1'b1;
      repeat (SYNC_N + 4) tick();
      exp_high = h;
      exp_period = h + l;
      reg_rd(REG_HIGH, v);
      n_checks++;
      if (v !== exp_high) begin
        n_fail++;
        $display("FAIL rand_high h=%0d l=%0d: got %0d expected %0d", h, l, v, exp_high);
      end
      reg_rd(REG_PERIOD, v);
      n_checks++;
      if (v !== exp_period) begin
        n_fail++;
        $display("FAIL rand_period h=%0d l=%0d: got %0d expected %0d", h, l, v, exp_period);
      end
      reg_rd(REG_STATUS, v);
      n_checks++;
      if (v !== 32'd1) begin
        n_fail++;
        $display("FAIL rand_status h=%0d l=%0d: got 0x%0h expected 0x1", h, l, v);
      end
    end
  endtask

  task automatic test_irq();
    logic [31:0] v;
    int vc, ic;
    restart(32'd3);
    pulse(4, 4);
    pwm_in = 1'b1;
    vc = -1;
    ic = -1;
    for (int c = 0; c < 40; c++) begin
      reg_rd(REG_STATUS, v);
      if (v[0] && vc < 0) vc = c;
      if (irq && ic < 0) ic = c;
      tick();
    end
    exp_high = 4;
    exp_period = 8;
    n_checks++;
    if (vc < 0) begin
      n_fail++;
      $display("FAIL irq_valid_timeout: got no valid within 40 cycles, expected valid");
    end
    n_checks++;
    if (vc >= 0 && ic !== vc + 1) begin
      n_fail++;
      $display("FAIL irq_latency: got irq at cycle %0d expected %0d", ic, vc + 1);
    end
    reg_wr(REG_STATUS, 32'd1);
    reg_rd(REG_STATUS, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_fail++;
      $display("FAIL irq_clear_valid: got 0x%0h expected 0x0", v);
    end
    tick();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear_irq: got %b expected 0", irq);
    end
  endtask

  task automatic test_set_wins();
    logic [31:0] v;
    restart(32'd1);
    pulse(3, 4);
    pwm_in = 1'b1;
    repeat (SYNC_N) tick();
    reg_rd(REG_STATUS, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_fail++;
      $display("FAIL setwins_pre: got 0x%0h expected 0x0", v);
    end
    reg_wr(REG_STATUS, 32'd1);
    reg_rd(REG_STATUS, v);
    n_checks++;
    if (v !== 32'd1) begin
      n_fail++;
      $display("FAIL setwins_valid: got 0x%0h expected 0x1", v);
    end
    exp_high = 3;
    exp_period = 7;
    reg_rd(REG_PERIOD, v);
    n_checks++;
    if (v !== exp_period) begin
      n_fail++;
      $display("FAIL setwins_period: got %0d expected %0d", v, exp_period);
    end
  endtask

  task automatic test_ovf();
    logic [31:0] v;
    int vc, oc;
    restart(32'd1);
    pulse(2, 3);
    pwm_in = 1'b1;
    vc = -1;
    oc = -1;
    for (int c = 0; c < 400; c++) begin
      reg_rd(REG_STATUS, v);
      if (v[0] && vc < 0) vc = c;
      if (v[1] && oc < 0) oc = c;
      tick();
    end
    exp_high = 2;
    exp_period = 5;
    n_checks++;
    if (vc < 0 || oc < 0) begin
      n_fail++;
      $display("FAIL ovf_timeout: got valid@%0d ovf@%0d expected both seen", vc, oc);
    end
    n_checks++;
    if (oc - vc !== (1 << CW) - 1) begin
      n_fail++;
      $display("FAIL ovf_timing: got %0d cycles expected %0d", oc - vc, (1 << CW) - 1);
    end
    reg_rd(REG_STATUS, v);
    n_checks++;
    if (v !== 32'd3) begin
      n_fail++;
      $display("FAIL ovf_status: got 0x%0h expected 0x3", v);
    end
    reg_rd(REG_HIGH, v);
    n_checks++;
    if (v !== exp_high) begin
      n_fail++;
      $display("FAIL ovf_high: got %0d expected %0d", v, exp_high);
    end
    reg_rd(REG_PERIOD, v);
    n_checks++;
    if (v !== exp_period) begin
      n_fail++;
      $display("FAIL ovf_period: got %0d expected %0d", v, exp_period);
    end
    n_checks++;
    if (dut.state !== ST_WAIT_RISE) begin
      n_fail++;
      $display("FAIL ovf_state: got %0d expected %0d", dut.state, ST_WAIT_RISE);
    end
  endtask

  task automatic test_disable();
    logic [31:0] v;
    reg_wr(REG_CTRL, 32'd0);
    tick();
    reg_rd(REG_HIGH, v);
    n_checks++;
    if (v !== exp_high) begin
      n_fail++;
      $display("FAIL dis_keep_high: got %0d expected %0d", v, exp_high);
    end
    reg_rd(REG_PERIOD, v);
    n_checks++;
    if (v !== exp_period) begin
      n_fail++;
      $display("FAIL dis_keep_period: got %0d expected %0d", v, exp_period);
    end
    reg_rd(REG_STATUS, v);
    n_checks++;
    if (v !== 32'd3) begin
      n_fail++;
      $display("FAIL dis_keep_status: got 0x%0h expected 0x3", v);
    end
    restart(32'd1);
    pwm_in = 1'b1;
    repeat (SYNC_N + 3) tick();
    reg_wr(REG_CTRL, 32'd0);
    reg_wr(REG_CTRL, 32'd1);
    repeat (3) tick();
    pwm_in = 1'b0;
    repeat (5) tick();
    pulse(3, 6);
    reg_rd(REG_STATUS, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_fail++;
      $display("FAIL dis_no_spurious: got 0x%0h expected 0x0", v);
    end
    pwm_in = 1'b1;
    repeat (SYNC_N + 4) tick();
    exp_high = 3;
    exp_period = 9;
    reg_rd(REG_STATUS, v);
    n_checks++;
    if (v !== 32'd1) begin
      n_fail++;
      $display("FAIL dis_valid: got 0x%0h expected 0x1", v);
    end
    reg_rd(REG_PERIOD, v);
    n_checks++;
    if (v !== exp_period) begin
      n_fail++;
      $display("FAIL dis_period: got %0d expected %0d", v, exp_period);
    end
    reg_rd(REG_HIGH, v);
    n_checks++;
    if (v !== exp_high) begin
      n_fail++;
      $display("FAIL dis_high: got %0d expected %0d", v, exp_high);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    reg_wr(REG_CTRL, 32'd3);
    pwm_in = 1'b0;
    repeat (SYNC_N + 3) tick();
    n_checks++;
    if (dut.state !== ST_MEAS_LOW) begin
      n_fail++;
      $display("FAIL rstmid_pre_state: got %0d expected %0d", dut.state, ST_MEAS_LOW);
    end
    pwm_resetn = 1'b0;
    repeat (2) tick();
    pwm_resetn = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) begin
      reg_rd(a[1:0], v);
      n_checks++;
      if (v !== 32'd0) begin
        n_fail++;
        $display("FAIL rstmid_rd[%0d]: got 0x%08h expected 0x00000000", a, v);
      end
    end
    n_checks++;
    if (irq !== 1'b0 || dut.state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL rstmid_idle: got irq=%b state=%0d expected irq=0 state=%0d", irq, dut.state, ST_IDLE);
    end
    pulse(3, 3);
    pulse(3, 3);
    pwm_in = 1'b1;
    repeat (SYNC_N + 4) tick();
    reg_rd(REG_STATUS, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_fail++;
      $display("FAIL rstmid_no_capture: got 0x%0h expected 0x0", v);
    end
    exp_high = 0;
    exp_period = 0;
  endtask

  task automatic test_ro();
    logic [31:0] v;
    reg_wr(REG_HIGH, 32'hFFFF_FFFF);
    reg_wr(REG_PERIOD, 32'hFFFF_FFFF);
    reg_rd(REG_HIGH, v);
    n_checks++;
    if (v !== exp_high) begin
      n_fail++;
      $display("FAIL ro_high: got 0x%0h expected 0x%0h", v, exp_high);
    end
    reg_rd(REG_PERIOD, v);
    n_checks++;
    if (v !== exp_period) begin
      n_fail++;
      $display("FAIL ro_period: got 0x%0h expected 0x%0h", v, exp_period);
    end
    reg_wr(REG_CTRL, 32'hFFFF_FFFE);
    reg_rd(REG_CTRL, v);
    n_checks++;
    if (v !== 32'd2) begin
      n_fail++;
      $display("FAIL ro_ctrl_mask: got 0x%0h expected 0x2", v);
    end
    reg_wr(REG_CTRL, 32'hFFFF_FFFF);
    reg_rd(REG_CTRL, v);
    n_checks++;
    if (v !== 32'd3) begin
      n_fail++;
      $display("FAIL ro_ctrl_all: got 0x%0h expected 0x3", v);
    end
    reg_wr(REG_CTRL, 32'd0);
  endtask

  initial begin
    test_reset();
    test_capture();
    test_random();
    test_irq();
    test_set_wins();
    test_ovf();
    test_disable();
    test_reset_mid();
    test_ro();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nf_pwm_cap.md
NF_PWM_CAP -- requirements
Module: nf_pwm_cap

Interface
REQ-001 The block SHALL have parameter CW, default 16, meaning the width of the capture counters and result registers.
REQ-002 The block SHALL have parameter SYNC_N, default 2, meaning the number of synchronizer flops on pwm_in.
REQ-003 The block SHALL have port pwm_clk  input  1  capture clock; all logic SHALL be clocked on its rising edge.
REQ-004 The block SHALL have port pwm_resetn  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port pwm_in  input  1  asynchronous PWM signal to measure, e.g. the nf_pwm output.
REQ-006 The block SHALL have port addr  input  32  register address; only addr[3:2] SHALL be decoded.
REQ-007 The block SHALL have port we  input  1  write strobe, one write per cycle.
REQ-008 The block SHALL have port wd  input  32  write data.
REQ-009 The block SHALL have port rd  output  32  read data; combinational from addr, upper bits zero.
REQ-010 The block SHALL have port irq  output  1  registered interrupt request.

Function
REQ-011 The register map SHALL be: addr[3:2]=0 CTRL (bit0 en, bit1 irq_en, R/W); 1 STATUS (bit0 valid, bit1 ovf, write-1-to-clear); 2 HIGH (RO, CW bits); 3 PERIOD (RO, CW bits).
REQ-012 pwm_in SHALL pass through SYNC_N flops, then one more flop for edge detection; a pin edge SHALL be detected SYNC_N+1 cycles after it is sampled.
REQ-013 The FSM SHALL have states IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW.
REQ-014 Transitions SHALL be: IDLE->WAIT_RISE when en=1; WAIT_RISE->MEAS_HIGH on rise; MEAS_HIGH->MEAS_LOW on fall; MEAS_LOW->MEAS_HIGH on rise; any state->IDLE when en=0.
REQ-015 On each detected rise in WAIT_RISE or MEAS_LOW, cnt SHALL load 1; otherwise, in MEAS_HIGH and MEAS_LOW, cnt SHALL increment by 1 per cycle.
REQ-016 On a fall in MEAS_HIGH, high_tmp SHALL latch cnt.
REQ-017 On a rise in MEAS_LOW: HIGH SHALL latch high_tmp, PERIOD SHALL latch cnt, and valid SHALL be set in the next cycle.
REQ-018 Example: high 3 cycles, low 5 cycles SHALL give HIGH=3, PERIOD=8.
REQ-019 If cnt reaches 2^CW-1 in MEAS_HIGH or MEAS_LOW, then ovf SHALL be set, the FSM SHALL go to WAIT_RISE, and HIGH/PERIOD SHALL be unchanged.
REQ-020 If a write-1-to-clear and a hardware set of the same STATUS bit occur in one cycle, the set SHALL win.
REQ-021 Disabling mid-measurement SHALL discard the partial count and retain HIGH, PERIOD and STATUS.
REQ-022 irq SHALL be registered as irq_en & (valid | ovf), with one cycle of latency.
REQ-023 Writes to HIGH or PERIOD SHALL be ignored; wd bits above the defined fields SHALL be ignored.

Reset
REQ-024 Asserting pwm_resetn SHALL clear all flops: state=IDLE, cnt=0, high_tmp=0, HIGH=0, PERIOD=0, CTRL=0, valid=0, ovf=0, irq=0, and synchronizer flops=0.
REQ-025 Reset asserted mid-measurement SHALL return the block to IDLE with no capture.
REQ-026 After reset, rd SHALL read 0 at every address.

Structure
REQ-027 The FSM state enum and the register offsets SHALL live in the shared package nf_settings.
REQ-028 The synchronizer SHALL be a separate sub-module nf_sync, parameterized on width and number of stages.

Verification
REQ-029 The bench SHALL set en=1 and drive pwm_in high 3 / low 5 repeatedly -> HIGH=3, PERIOD=8, STATUS=0x1.
REQ-030 The bench SHALL set irq_en=1, wait for the first capture, then write STATUS=0x1 -> irq rises one cycle after valid; valid and irq drop after the clear.
REQ-031 The bench SHALL hold pwm_in high constantly with CW=8 after a rise -> ovf=1 at cnt=255; HIGH and PERIOD unchanged; the FSM returns to WAIT_RISE.
REQ-032 The bench SHALL write STATUS=0x1 in the same cycle as a capture -> valid stays 1.
REQ-033 The bench SHALL write en=0 mid-high-phase, then en=1 -> no spurious capture; the next valid result appears only after the second full period following the first rise.
REQ-034 The bench SHALL assert pwm_resetn mid-MEAS_LOW -> all registers read 0 and the FSM is in IDLE.
